// File: rtl/score_display_mux.sv
// score_display_mux: saturating BCD score counter with edge-detected
// increment/decrement requests and a time-multiplexed, common-anode
// seven-segment display driver (active-low anodes and segments).
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module score_display_mux #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  increment_score,
  input  logic                  decrement_score,
  input  logic                  clear_score,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  score_max,
  output logic [DIGITS-1:0]     anode_activate,
  output logic [7:0]            LED_out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic                inc_prev_reg, dec_prev_reg;
  logic                inc_evt, dec_evt;
  logic [4*DIGITS-1:0] score_reg, score_next, score_inc, score_dec;
  logic [DIGITS-1:0]   digit_is9;
  logic                at_max, at_zero;
  logic [PRE_W-1:0]    prescaler_reg;
  logic [IDX_W-1:0]    digit_idx_reg;
  logic [DIGITS-1:0]   anode_reg, anode_next;
  logic [7:0]          led_reg, led_next;
  logic [3:0]          sel_digit;
  logic                blank_digit;

  // Active-low seven-segment code; anything outside 0..9 shows blank.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  assign inc_evt = increment_score & ~inc_prev_reg;
  assign dec_evt = decrement_score & ~dec_prev_reg;

  // Per-digit "is 9" flags and one-hot (active-low) anode pattern.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_is9[gi]  = (score_reg[4*gi +: 4] == 4'd9);
      assign anode_next[gi] = (digit_idx_reg != IDX_W'(gi));
    end
  endgenerate

  assign at_max  = &digit_is9;
  assign at_zero = (score_reg == '0);

  // Digit-wise ripple increment: a 9 wraps to 0 and carries upward.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    score_inc = score_reg;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (score_reg[4*k +: 4] == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
        end else begin
          score_inc[4*k +: 4] = score_reg[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Digit-wise ripple decrement: a 0 wraps to 9 and borrows upward.
  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    score_dec = score_reg;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (score_reg[4*k +: 4] == 4'd0) begin
          score_dec[4*k +: 4] = 4'd9;
        end else begin
          score_dec[4*k +: 4] = score_reg[4*k +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Score update priority: clear, then coincident events cancel, then +1/-1 with saturation.
  always_comb begin
    score_next = score_reg;
    if (clear_score)               score_next = '0;
    else if (inc_evt && dec_evt)   score_next = score_reg;
    else if (inc_evt && !at_max)   score_next = score_inc;
    else if (dec_evt && !at_zero)  score_next = score_dec;
  end

  // Edge-detect history and score state.
  always_ff @(posedge clock) begin
    if (reset) begin
      inc_prev_reg <= 1'b0;
      dec_prev_reg <= 1'b0;
      score_reg    <= '0;
    end else begin
      inc_prev_reg <= increment_score;
      dec_prev_reg <= decrement_score;
      score_reg    <= score_next;
    end
  end

  // Refresh prescaler and scanned digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_reg <= '0;
      digit_idx_reg <= '0;
    end else if (prescaler_reg == PRE_W'(REFRESH_DIV - 1)) begin
      prescaler_reg <= '0;
      if (digit_idx_reg == IDX_W'(DIGITS - 1)) digit_idx_reg <= '0;
      else                                     digit_idx_reg <= digit_idx_reg + 1'b1;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
    end
  end

  // Select the BCD digit currently being scanned.
  always_comb begin
    sel_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx_reg == IDX_W'(k)) sel_digit = score_reg[4*k +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k]: digit k and every more-significant digit are zero.
  logic [DIGITS:0] zero_from;
  assign zero_from[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (score_reg[4*gi +: 4] == 4'd0) && zero_from[gi+1];
    end
  endgenerate

  // Blank a leading zero; digit 0 always shows so a zero score reads "0".
  always_comb begin
    blank_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx_reg == IDX_W'(k)) blank_digit = (k != 0) && zero_from[k];
    end
  end
`else
  assign blank_digit = 1'b0;
`endif

  assign led_next = blank_digit ? SEG_BLANK : seg_code(sel_digit);

  // Registered display outputs so anode and segments switch on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_reg <= '1;
      led_reg   <= SEG_BLANK;
    end else begin
      anode_reg <= anode_next;
      led_reg   <= led_next;
    end
  end

  assign score_bcd      = score_reg;
  assign score_max      = at_max;
  assign anode_activate = anode_reg;
  assign LED_out        = led_reg;

endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: randomized and directed stimulus for score_display_mux
// (DIGITS=4, REFRESH_DIV=4) checked against an integer-level reference model.
module tb_score_display_mux;

  localparam int DIGITS = 4;
  localparam int REFRESH_DIV = 4;
  localparam int MAX_SCORE = 9999;

  logic                clock = 1'b0;
  logic                reset;
  logic                increment_score;
  logic                decrement_score;
  logic                clear_score;
  logic [4*DIGITS-1:0] score_bcd;
  logic                score_max;
  logic [DIGITS-1:0]   anode_activate;
  logic [7:0]          LED_out;

  score_display_mux #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clock           (clock),
    .reset           (reset),
    .increment_score (increment_score),
    .decrement_score (decrement_score),
    .clear_score     (clear_score),
    .score_bcd       (score_bcd),
    .score_max       (score_max),
    .anode_activate  (anode_activate),
    .LED_out         (LED_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: score as a plain integer, scan as a count of edges.
  int         m_score;
  int         m_scan;
  logic       m_inc_prev, m_dec_prev;
  logic [3:0] m_anode;
  logic [7:0] m_led;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge, compare.
  task automatic tick();
    int  d, old;
    logic ie, de;
    @(posedge clock);
    if (reset) begin
      m_score = 0; m_scan = 0; m_inc_prev = 1'b0; m_dec_prev = 1'b0;
      m_anode = 4'hF; m_led = 8'hFF;
    end else begin
      old     = m_score;
      d       = (m_scan / REFRESH_DIV) % DIGITS;
      m_anode = ~(4'd1 << d);
      m_led   = seg_tab[(old / pow10(d)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && old < pow10(d)) m_led = 8'hFF;
`endif
      m_scan++;
      ie = increment_score && !m_inc_prev;
      de = decrement_score && !m_dec_prev;
      if (clear_score)                    m_score = 0;
      else if (ie && de)                  m_score = m_score;
      else if (ie && m_score < MAX_SCORE) m_score = m_score + 1;
      else if (de && m_score > 0)         m_score = m_score - 1;
      m_inc_prev = increment_score;
      m_dec_prev = decrement_score;
    end
    #1;
    check("score_bcd", 32'(score_bcd), to_bcd(m_score));
    check("score_max", 32'(score_max), 32'(m_score == MAX_SCORE));
    check("anode",     32'(anode_activate), 32'(m_anode));
    check("led",       32'(LED_out), 32'(m_led));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      increment_score = 1'b1; tick();
      increment_score = 1'b0; tick();
    end
  endtask

  task automatic pulse_dec(input int n);
    for (int i = 0; i < n; i++) begin
      decrement_score = 1'b1; tick();
      decrement_score = 1'b0; tick();
    end
  endtask

  task automatic do_clear();
    clear_score = 1'b1; tick();
    clear_score = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; increment_score = 1'b0; decrement_score = 1'b0; clear_score = 1'b0;
    m_score = 0; m_scan = 0; m_inc_prev = 1'b0; m_dec_prev = 1'b0;
    m_anode = 4'hF; m_led = 8'hFF;

    // Reset and scan of a zero score.
    run(2);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_anode", 32'(anode_activate), 32'hF);
    check("rst_led",   32'(LED_out), 32'hFF);
    reset = 1'b0;
    tick();
    check("first_anode", 32'(anode_activate), 32'hE);
    check("first_led",   32'(LED_out), 32'hC0);
    run(19);
    $display("scan after reset done, score=%h", score_bcd);

    // Held increment counts once.
    increment_score = 1'b1;
    run(200);
    check("hold200", 32'(score_bcd), 32'h0001);
    increment_score = 1'b0; tick();
    pulse_inc(1);
    check("second_pulse", 32'(score_bcd), 32'h0002);
    $display("held increment, score=%h", score_bcd);

    // Carries.
    do_clear();
    pulse_inc(9);
    pulse_inc(1);
    check("carry_10", 32'(score_bcd), 32'h0010);
    do_clear();
    pulse_inc(999);
    check("pre_999", 32'(score_bcd), 32'h0999);
    pulse_inc(1);
    check("carry_1000", 32'(score_bcd), 32'h1000);
    $display("carry tests, score=%h", score_bcd);

    // Saturation at the top.
    pulse_inc(8999);
    check("at_9999", 32'(score_bcd), 32'h9999);
    check("max_flag", 32'(score_max), 32'h1);
    pulse_inc(1);
    check("sat_9999", 32'(score_bcd), 32'h9999);
    pulse_dec(1);
    check("dec_9998", 32'(score_bcd), 32'h9998);
    check("max_clr", 32'(score_max), 32'h0);
    $display("saturation, score=%h", score_bcd);

    // Hold at zero.
    do_clear();
    pulse_dec(1);
    check("floor_0", 32'(score_bcd), 32'h0000);

    // Coincident rising edges cancel.
    pulse_inc(5);
    increment_score = 1'b1; decrement_score = 1'b1; tick();
    increment_score = 1'b0; decrement_score = 1'b0; tick();
    check("both_edges", 32'(score_bcd), 32'h0005);

    // Clear wins over increment.
    clear_score = 1'b1; increment_score = 1'b1; tick();
    clear_score = 1'b0; increment_score = 1'b0; tick();
    check("clear_inc", 32'(score_bcd), 32'h0000);
    $display("priority tests, score=%h", score_bcd);

    // Reset mid-scan at 0042, release with increment held.
    pulse_inc(42);
    run(5);
    reset = 1'b1; increment_score = 1'b1; tick();
    check("midrst_score", 32'(score_bcd), 32'h0);
    check("midrst_anode", 32'(anode_activate), 32'hF);
    check("midrst_led",   32'(LED_out), 32'hFF);
    reset = 1'b0; tick();
    check("rel_inc", 32'(score_bcd), 32'h0001);
    increment_score = 1'b0; tick();
    $display("mid-scan reset, score=%h", score_bcd);

    // Random traffic including occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      increment_score = 1'($urandom_range(0, 1));
      decrement_score = 1'($urandom_range(0, 1));
      clear_score     = ($urandom_range(0, 31) == 0);
      reset           = ($urandom_range(0, 127) == 0);
      tick();
    end
    reset = 1'b0; increment_score = 1'b0; decrement_score = 1'b0; clear_score = 1'b0;
    run(20);
    $display("random traffic done, score=%h", score_bcd);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
